// File: rtl/stack_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// stack_arbiter_pkg
//   Shared definitions for the stack arbiter slice: FSM state encoding,
//   transaction op encoding and a small helper to size index fields.
// -----------------------------------------------------------------------------
package stack_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Request op encoding, matching the REQ_POP bit (1 = pop, 0 = push).
  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_t;

  // Width of an index into n requesters; at least one bit so that the
  // degenerate single-requester case still yields a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. Starting at ptr and wrapping
//   upward, the first asserted request wins.
//
//   Ports:
//     req        in   NUM_REQ  request vector
//     ptr        in   IDX_W    highest-priority requester index
//     grant      out  NUM_REQ  one-hot grant (all-zero when no request)
//     grant_idx  out  IDX_W    encoded index of the granted requester
//     any_req    out  1        at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // Walk the requesters in priority order: ptr, ptr+1, ... wrapping.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//   Shares one LIFO stack among NUM_REQ requesters. Each requester presents
//   a push/pop over a valid/ready request channel; a round-robin winner is
//   accepted in IDLE, its op is issued to the stack in ISSUE (or rejected
//   when it would overflow/underflow), and the result is returned in RESP
//   until the owner accepts it. One transaction is in flight at a time.
//
//   Ports:
//     CLK        in   1                    clock
//     RST_N      in   1                    synchronous active-low reset
//     REQ_VALID  in   NUM_REQ              per-requester request valid
//     REQ_POP    in   NUM_REQ              per-requester op (1 = pop, 0 = push)
//     REQ_DATA   in   NUM_REQ*DATA_WIDTH   push data, requester i at [i*DW +: DW]
//     REQ_READY  out  NUM_REQ              one-hot accept pulse (IDLE only)
//     RSP_VALID  out  NUM_REQ              one-hot response valid to owner
//     RSP_READY  in   NUM_REQ              per-requester response accept
//     RSP_DATA   out  DATA_WIDTH           response data (0 on error)
//     RSP_ERR    out  1                    response error flag
//     STK_PUSH   out  1                    stack push strobe (ISSUE only)
//     STK_POP    out  1                    stack pop strobe (ISSUE only)
//     STK_DIN    out  DATA_WIDTH           stack write data
//     STK_DOUT   in   DATA_WIDTH           stack registered output
//     STK_FULL   in   1                    stack full flag
//     STK_EMPTY  in   1                    stack empty flag
//     BUSY       out  1                    FSM not in IDLE
//     ERR_CNT    out  ERR_CNT_WIDTH        saturating count of rejected ops
// -----------------------------------------------------------------------------
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 2,
  parameter int NUM_REQ       = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_POP,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  input  logic [NUM_REQ-1:0]            RSP_READY,
  output logic [DATA_WIDTH-1:0]         RSP_DATA,
  output logic                          RSP_ERR,
  output logic                          STK_PUSH,
  output logic                          STK_POP,
  output logic [DATA_WIDTH-1:0]         STK_DIN,
  input  logic [DATA_WIDTH-1:0]         STK_DOUT,
  input  logic                          STK_FULL,
  input  logic                          STK_EMPTY,
  output logic                          BUSY,
  output logic [ERR_CNT_WIDTH-1:0]      ERR_CNT
);

  localparam int IDX_W = idx_width(NUM_REQ);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           rr_ptr_q;
  logic [IDX_W-1:0]           owner_q;
  op_t                        op_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic                       err_q;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (REQ_VALID),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] owner_oh;
  logic               op_legal;
  logic               rsp_ack;

  assign owner_oh = NUM_REQ'(1) << owner_q;

  // Sampled only in ISSUE; the one-cycle gap after the previous op's strobe
  // means FULL/EMPTY already reflect that op by then.
  assign op_legal = (op_q == OP_PUSH) ? !STK_FULL : !STK_EMPTY;

  // Only the owner's RSP_READY can complete the response.
  assign rsp_ack  = |(RSP_READY & owner_oh);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // NOTE: every output and next-state value gets a default before the case
  // statement so no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    REQ_READY = '0;
    RSP_VALID = '0;
    RSP_DATA  = '0;
    RSP_ERR   = 1'b0;
    STK_PUSH  = 1'b0;
    STK_POP   = 1'b0;
    STK_DIN   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          REQ_READY = grant;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (op_legal) begin
          if (op_q == OP_PUSH) begin
            STK_PUSH = 1'b1;
            STK_DIN  = data_q;
          end else begin
            STK_POP  = 1'b1;
          end
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        RSP_VALID = owner_oh;
        RSP_ERR   = err_q;
        // STK_DOUT is the stack's own register and no strobe is issued while
        // in RESP, so it holds the op's result steady for the whole response.
        RSP_DATA  = err_q ? '0 : STK_DOUT;
        if (rsp_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous (sampled on the clock edge like any other input),
  // so it lives inside the posedge-only block rather than in the sensitivity list.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      op_q      <= OP_PUSH;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      unique case (state_q)
        ST_IDLE: begin
          // Request fields are captured only in the accept cycle.
          if (any_req) begin
            owner_q <= grant_idx;
            op_q    <= op_t'(REQ_POP[grant_idx]);
            data_q  <= REQ_DATA[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          end
        end

        ST_ISSUE: begin
          err_q <= !op_legal;
          if (!op_legal && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
          end
        end

        ST_RESP: begin
          // Hand priority to the requester after the owner once it is served.
          if (rsp_ack) begin
            rr_ptr_q <= IDX_W'((int'(owner_q) + 1) % NUM_REQ);
          end
        end

        default: ;
      endcase
    end
  end

  assign BUSY    = (state_q != ST_IDLE);
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stack_arbiter
//   Drives stack_arbiter with two requesters against a small behavioural
//   LIFO (depth 4) hooked to the STK_* ports. A forced-full override lets the
//   bench exercise push-on-full without filling the stack.
// -----------------------------------------------------------------------------
module tb_stack_arbiter;

  localparam int DW    = 2;
  localparam int NR    = 2;
  localparam int CW    = 8;
  localparam int DEPTH = 4;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [NR-1:0]   REQ_VALID;
  logic [NR-1:0]   REQ_POP;
  logic [NR*DW-1:0] REQ_DATA;
  logic [NR-1:0]   REQ_READY;
  logic [NR-1:0]   RSP_VALID;
  logic [NR-1:0]   RSP_READY;
  logic [DW-1:0]   RSP_DATA;
  logic            RSP_ERR;
  logic            STK_PUSH;
  logic            STK_POP;
  logic [DW-1:0]   STK_DIN;
  logic [DW-1:0]   STK_DOUT;
  logic            STK_FULL;
  logic            STK_EMPTY;
  logic            BUSY;
  logic [CW-1:0]   ERR_CNT;

  always #5 CLK = ~CLK;

  stack_arbiter #(
    .DATA_WIDTH    (DW),
    .NUM_REQ       (NR),
    .ERR_CNT_WIDTH (CW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_POP   (REQ_POP),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_DATA  (RSP_DATA),
    .RSP_ERR   (RSP_ERR),
    .STK_PUSH  (STK_PUSH),
    .STK_POP   (STK_POP),
    .STK_DIN   (STK_DIN),
    .STK_DOUT  (STK_DOUT),
    .STK_FULL  (STK_FULL),
    .STK_EMPTY (STK_EMPTY),
    .BUSY      (BUSY),
    .ERR_CNT   (ERR_CNT)
  );

  // ---------------------------------------------------------------------------
  // Behavioural LIFO: registered output, echoes pushed data, returns top on pop.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];
  logic [2:0]    sp;
  logic [DW-1:0] dout;
  logic          force_full;

  always @(posedge CLK) begin
    if (!RST_N) begin
      sp   <= '0;
      dout <= '0;
    end else if (STK_PUSH && (sp != 3'(DEPTH))) begin
      mem[sp[1:0]] <= STK_DIN;
      sp           <= sp + 3'd1;
      dout         <= STK_DIN;
    end else if (STK_POP && (sp != 3'd0)) begin
      dout <= mem[2'(sp - 3'd1)];
      sp   <= sp - 3'd1;
    end
  end

  assign STK_DOUT  = dout;
  assign STK_FULL  = (sp == 3'(DEPTH)) | force_full;
  assign STK_EMPTY = (sp == 3'd0);

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full single-requester transaction, entered just after a negedge with
  // the DUT in IDLE and left just after a negedge with the DUT back in IDLE.
  task automatic do_txn(input int req, input logic pop, input logic [DW-1:0] data,
                        input logic exp_err, input logic [DW-1:0] exp_data);
    logic [NR-1:0] oh;
    oh = NR'(1) << req;
    REQ_VALID = oh;
    REQ_POP   = pop ? oh : '0;
    REQ_DATA  = '0;
    REQ_DATA[req*DW +: DW] = data;
    #1;
    check("accept_ready", REQ_READY, oh);
    check("accept_busy", BUSY, 1'b0);

    // ISSUE: request fields are scrambled to confirm they were latched.
    @(negedge CLK);
    REQ_VALID = '0;
    REQ_DATA  = '1;
    #1;
    check("issue_push", STK_PUSH, !pop && !exp_err);
    check("issue_pop", STK_POP, pop && !exp_err);
    check("issue_din", STK_DIN, (!pop && !exp_err) ? data : 2'b00);
    check("issue_ready", REQ_READY, 2'b00);
    if (exp_err && exp_cnt < 255) exp_cnt++;

    // RESP
    @(negedge CLK);
    #1;
    check("rsp_valid", RSP_VALID, oh);
    check("rsp_err", RSP_ERR, exp_err);
    check("rsp_data", RSP_DATA, exp_data);
    check("rsp_err_cnt", ERR_CNT, exp_cnt);
    RSP_READY = oh;

    @(negedge CLK);
    RSP_READY = '0;
    #1;
    check("done_valid", RSP_VALID, 2'b00);
    check("done_busy", BUSY, 1'b0);
  endtask

  typedef struct {
    int            req;
    logic          pop;
    logic [DW-1:0] data;
    logic          exp_err;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [NR-1:0] oh;
    logic [DW-1:0] d;

    RST_N      = 1'b0;
    REQ_VALID  = '0;
    REQ_POP    = '0;
    REQ_DATA   = '0;
    RSP_READY  = '0;
    force_full = 1'b0;

    //            req pop data   err   rdata
    vecs[0]  = '{1, 1'b1, 2'd0, 1'b1, 2'd0};  // pop on empty from reset
    vecs[1]  = '{0, 1'b0, 2'd2, 1'b0, 2'd2};  // single push 2'b10
    vecs[2]  = '{1, 1'b0, 2'd1, 1'b0, 2'd1};
    vecs[3]  = '{0, 1'b1, 2'd0, 1'b0, 2'd1};  // LIFO order
    vecs[4]  = '{1, 1'b1, 2'd0, 1'b0, 2'd2};
    vecs[5]  = '{0, 1'b1, 2'd0, 1'b1, 2'd0};  // empty again
    vecs[6]  = '{1, 1'b0, 2'd3, 1'b0, 2'd3};
    vecs[7]  = '{0, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[8]  = '{1, 1'b0, 2'd1, 1'b0, 2'd1};
    vecs[9]  = '{0, 1'b0, 2'd2, 1'b0, 2'd2};  // stack now full
    vecs[10] = '{1, 1'b0, 2'd3, 1'b1, 2'd0};  // push on real full
    vecs[11] = '{0, 1'b1, 2'd0, 1'b0, 2'd2};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("rst_req_ready", REQ_READY, 2'b00);
    check("rst_rsp_valid", RSP_VALID, 2'b00);
    check("rst_rsp_data", RSP_DATA, 2'b00);
    check("rst_rsp_err", RSP_ERR, 1'b0);
    check("rst_stk_push", STK_PUSH, 1'b0);
    check("rst_stk_pop", STK_POP, 1'b0);
    check("rst_stk_din", STK_DIN, 2'b00);
    check("rst_busy", BUSY, 1'b0);
    check("rst_err_cnt", ERR_CNT, 8'd0);
    RST_N = 1'b1;

    // Directed single-requester table.
    foreach (vecs[i])
      do_txn(vecs[i].req, vecs[i].pop, vecs[i].data, vecs[i].exp_err, vecs[i].exp_data);

    // Push on forced full, enough times to saturate the error counter.
    force_full = 1'b1;
    for (int i = 0; i < 300; i++)
      do_txn(0, 1'b0, 2'd1, 1'b1, 2'd0);
    check("sat_err_cnt", ERR_CNT, 8'd255);
    force_full = 1'b0;

    // Reset in the ISSUE cycle of a push from req1 (rr pointer is 1 here).
    REQ_VALID = 2'b10;
    REQ_POP   = 2'b00;
    REQ_DATA  = 4'b0100;
    #1;
    check("rstmid_accept", REQ_READY, 2'b10);
    @(negedge CLK);
    REQ_VALID = '0;
    RST_N     = 1'b0;
    #1;
    check("rstmid_issue_push", STK_PUSH, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rstmid_push", STK_PUSH, 1'b0);
    check("rstmid_pop", STK_POP, 1'b0);
    check("rstmid_rsp_valid", RSP_VALID, 2'b00);
    check("rstmid_busy", BUSY, 1'b0);
    check("rstmid_err_cnt", ERR_CNT, 8'd0);
    exp_cnt = 0;

    // Fairness: both requesters held valid; first grant must be req0.
    REQ_VALID = 2'b11;
    REQ_POP   = 2'b00;
    REQ_DATA  = {2'd2, 2'd1};
    for (int k = 0; k < 4; k++) begin
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      d  = (k % 2 == 0) ? 2'd1  : 2'd2;
      #1;
      check($sformatf("fair%0d_ready", k), REQ_READY, oh);
      @(negedge CLK);
      #1;
      check($sformatf("fair%0d_issue_ready", k), REQ_READY, 2'b00);
      check($sformatf("fair%0d_push", k), STK_PUSH, 1'b1);
      check($sformatf("fair%0d_din", k), STK_DIN, d);
      @(negedge CLK);
      #1;
      check($sformatf("fair%0d_rsp_valid", k), RSP_VALID, oh);
      check($sformatf("fair%0d_rsp_data", k), RSP_DATA, d);
      check($sformatf("fair%0d_rsp_ready", k), REQ_READY, 2'b00);
      RSP_READY = 2'b11;
      @(negedge CLK);
      RSP_READY = '0;
    end

    // Backpressure: req0 pops (top = 2), req1 waits with a push of 3.
    REQ_VALID = 2'b11;
    REQ_POP   = 2'b01;
    REQ_DATA  = {2'd3, 2'd0};
    #1;
    check("bp_accept", REQ_READY, 2'b01);
    @(negedge CLK);
    #1;
    check("bp_issue_pop", STK_POP, 1'b1);
    check("bp_issue_push", STK_PUSH, 1'b0);
    @(negedge CLK);
    RSP_READY = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d_rsp_valid", k), RSP_VALID, 2'b01);
      check($sformatf("bp%0d_rsp_data", k), RSP_DATA, 2'd2);
      check($sformatf("bp%0d_rsp_err", k), RSP_ERR, 1'b0);
      check($sformatf("bp%0d_req_ready", k), REQ_READY, 2'b00);
      check($sformatf("bp%0d_busy", k), BUSY, 1'b1);
      @(negedge CLK);
    end
    RSP_READY = 2'b01;
    #1;
    check("bp_hs_valid", RSP_VALID, 2'b01);
    @(negedge CLK);
    RSP_READY = '0;
    #1;
    check("bp_next_ready", REQ_READY, 2'b10);
    check("bp_next_rsp_valid", RSP_VALID, 2'b00);
    @(negedge CLK);
    REQ_VALID = '0;
    #1;
    check("bp_r1_push", STK_PUSH, 1'b1);
    check("bp_r1_din", STK_DIN, 2'd3);
    @(negedge CLK);
    #1;
    check("bp_r1_rsp_valid", RSP_VALID, 2'b10);
    check("bp_r1_rsp_data", RSP_DATA, 2'd3);
    check("bp_r1_rsp_err", RSP_ERR, 1'b0);
    RSP_READY = 2'b10;
    @(negedge CLK);
    RSP_READY = '0;
    #1;
    check("bp_r1_done_busy", BUSY, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
